btn_sw_input: RTL
=================

Name: btn_sw_input

Overview:
- Input-side peripheral interface: the read path, complementing the write-only 7-seg and LED interfaces.
- Synchronises and debounces raw switches[23:0] and button[4:0].
- Captures button press events into read-to-clear sticky bits, and keeps a saturating press counter.
- Presents four 32-bit read registers to the bus bridge; replaces the direct zero-extended switch/button wiring at the bridge's sw/btn ports.

Parameters:
SAMPLE_DIV, 50000, sample-tick period in clk cycles (≥2).
STABLE_TICKS, 4, consecutive ticks an input must differ from its debounced value before that value updates (1..7).

Ports:
clk  input  1  peripheral clock, rising edge.
rst  input  1  asynchronous reset, active-low.
switches  input  24  raw switch levels, asynchronous.
button  input  5  raw button levels, asynchronous.
addr  input  12  byte offset from bridge; only addr[3:2] decoded.
rd_en  input  1  bridge read strobe, one cycle per CPU load.
rdata  output  32  read data, combinational from addr and current state.

Behaviour:
- Reset (rst=0, async): all sync flops, debounced state, per-bit counters, prescaler, evt and press_cnt cleared to 0. rdata then reflects zeros for every addr.
- Synchroniser: 2-flop per input bit gives `sync`.
- Prescaler:
  - Free-runs 0..SAMPLE_DIV-1, wraps to 0.
  - `tick`=1 in the cycle the prescaler equals SAMPLE_DIV-1.
- Debounce, per bit (29 bits), 3-bit counter `cnt`, evaluated only on tick:
  - If sync != stable and cnt == STABLE_TICKS-1: stable <= sync, cnt <= 0.
  - Else if sync != stable: cnt++.
  - Else: cnt <= 0, so a glitch shorter than STABLE_TICKS ticks never propagates.
  - Latency from a raw change to stable: 2 cycles plus the STABLE_TICKS-th tick after sync changes.
- Press event: rise = stable_btn & ~stable_btn_prev, evaluated every cycle.
  - evt[i] is set on rise[i].
  - A read with rd_en=1 and addr[3:2]=2 clears evt at the following clock edge.
  - If set and clear occur in the same cycle, set wins: bit stays 1.
  - The read returns the pre-clear value.
- press_cnt (16b): adds popcount(rise) each cycle and saturates at 0xFFFF (no wrap). Not cleared by reads.
- Register map (rdata), addr[3:2]:
  - 0: {8'b0, stable_sw[23:0]}
  - 1: {27'b0, stable_btn[4:0]}
  - 2: {19'b0, evt_rel[4:0] (optional, else 0), 3'b0, evt[4:0]}; evt_rel occupies bits [12:8].
  - 3: {16'b0, press_cnt}
- rd_en with addr[3:2] != 2 has no side effect. rd_en is ignored during reset.
- Button held through reset: stable rises after debounce and sets evt (intended; software clears at boot).

Optional Feature:
- Macro BTN_RELEASE_EVT_EN.
- Defined:
  - Adds evt_rel[4:0], set on a debounced 1->0 button transition.
  - Cleared by the same read-to-clear as evt, with set-wins precedence.
  - Visible in reg 2 bits [12:8]. Releases do not increment press_cnt.
- Undefined: bits [12:8] of reg 2 read 0 and no release logic is synthesised.

Test Plan (SAMPLE_DIV=4, STABLE_TICKS=4):
1. Reset mid-operation: press button[0], wait 30 cycles, pulse rst low 1 cycle -> rdata=0 at every addr immediately. button[0] still held -> evt[0] sets again after 15..18 cycles.
2. Debounce latency: switches=0x00A5C3 stepped at cycle 0 -> addr 0x0 reads 0 up to cycle 14, reads 0x000000A5C3 no later than cycle 18.
3. Glitch rejection: button[2] high for 9 cycles, then low -> stable_btn, evt and press_cnt all stay 0.
4. Read-to-clear:
   - Press buttons 1 and 3 (debounced) -> addr 0x8 reads 0x0000000A and press_cnt=2.
   - Read with rd_en -> next read of 0x8 returns 0; addr 0xC still 0x00000002.
5. Set/clear collision: rd_en at addr 0x8 in the same cycle rise[4]=1 -> evt[4]=1 afterwards.
6. Saturation: force press_cnt=0xFFFE, press buttons 0 and 1 simultaneously -> 0xFFFF. Further presses hold 0xFFFF.
   - With BTN_RELEASE_EVT_EN: releasing them sets reg 2 bits [9:8].

Source files
------------

// File: rtl/btn_sw_input.sv
// Switch/button read peripheral: synchronise, debounce, sticky press events, saturating press counter.
// Optional macro BTN_RELEASE_EVT_EN adds sticky release events in register 2 bits [12:8].
module btn_sw_input #(
  parameter int unsigned SAMPLE_DIV   = 50000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] switches,
  input  logic [4:0]  button,
  input  logic [11:0] addr,
  input  logic        rd_en,
  output logic [31:0] rdata
);

  localparam int unsigned NB = 29;
  localparam int unsigned PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
  localparam logic [2:0]    CNT_MAX   = 3'(STABLE_TICKS - 1);

  logic [NB-1:0]      sync1;
  logic [NB-1:0]      sync2;
  logic [NB-1:0]      stable;
  logic [NB-1:0][2:0] cnt;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [4:0]         btn_prev;
  logic [4:0]         rise;
  logic [4:0]         evt;
  logic [4:0]         evt_rel_rd;
  logic [15:0]        press_cnt;
  logic [2:0]         rise_cnt;
  logic [16:0]        cnt_sum;
  logic               clr;
  logic               unused_addr;

  assign unused_addr = ^{addr[11:4], addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {button, switches};
      sync2 <= sync1;
    end
  end

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else      presc <= tick ? '0 : presc + PW'(1);
  end

  // A bit only moves once it has disagreed with its debounced value for STABLE_TICKS ticks in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      // NOTE: the per-bit counters are ordinary flops, not RAM, so they are cleared with everything else.
      cnt    <= '0;
    end else if (tick) begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 3'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = stable[28:24] & ~btn_prev;
  assign clr  = rd_en && (addr[3:2] == 2'd2);

  always_comb begin
    // NOTE: blocking accumulation is correct here; this is a combinational sum, not state.
    rise_cnt = '0;
    for (int i = 0; i < 5; i++) rise_cnt = rise_cnt + 3'(rise[i]);
  end

  assign cnt_sum = {1'b0, press_cnt} + {14'b0, rise_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev  <= '0;
      evt       <= '0;
      press_cnt <= '0;
    end else begin
      btn_prev  <= stable[28:24];
      evt       <= (evt & ~{5{clr}}) | rise;
      press_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [4:0] fall;
  logic [4:0] evt_rel;

  assign fall = ~stable[28:24] & btn_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) evt_rel <= '0;
    else      evt_rel <= (evt_rel & ~{5{clr}}) | fall;
  end

  assign evt_rel_rd = evt_rel;
`else
  assign evt_rel_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0: rdata = {8'b0, stable[23:0]};
      2'd1: rdata = {27'b0, stable[28:24]};
      2'd2: rdata = {19'b0, evt_rel_rd, 3'b0, evt};
      2'd3: rdata = {16'b0, press_cnt};
      default: rdata = '0;
    endcase
  end

endmodule
